alu_exec_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 56 +++++
 rtl/alu_exec_pipe.sv | 117 +++++++++++
 tb/tb_alu_exec_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, shift-amount width and opsel codes.
// Also used by the ALU control decoder, so the codes here are the contract.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [2:0] OP_ADD  = 3'b000;  // add, or sub when sub=1
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;  // srl, or sra when sub=1
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus eq / signed-lt / unsigned-lt flags.
// One XLEN+1-bit subtractor feeds the flags and also supplies the sub result.
module alu_core #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      opsel,
  input  logic            sub,
  input  logic            unsigned_cmp,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);
  import alu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [XLEN:0]          diff;
  logic [XLEN-1:0]        sum;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_val;
  logic                   cmp_bit;

  // Zero-extended subtract: the top bit is the unsigned borrow.
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  assign sum   = op_a + op_b;
  assign shamt = op_b[SHW-1:0];

  assign eq  = (diff[XLEN-1:0] == '0);
  assign ltu = diff[XLEN];
  // Differing signs decide directly; otherwise the difference cannot overflow.
  assign lt  = (op_a[XLEN-1] != op_b[XLEN-1]) ? op_a[XLEN-1] : diff[XLEN-1];

  // Kept in its own signed net so >>> is never evaluated in an unsigned context.
  assign sra_val = $signed(op_a) >>> shamt;

  assign cmp_bit = unsigned_cmp ? ltu : lt;

  // Result select by opsel; sub/unsigned_cmp only refine the ops that use them.
  always_comb begin
    result = '0;
    case (opsel)
      OP_ADD:          result = sub ? diff[XLEN-1:0] : sum;
      OP_SLL:          result = op_a << shamt;
      OP_SLT, OP_SLTU: result[0] = cmp_bit;
      OP_XOR:          result = op_a ^ op_b;
      OP_SR:           result = sub ? sra_val : (op_a >> shamt);
      OP_OR:           result = op_a | op_b;
      OP_AND:          result = op_a & op_b;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage execute unit: S1 issue register -> alu_core -> S2 output register.
// Valid/ready on both sides with a skid-free stall chain; flush kills both stages.
module alu_exec_pipe #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_eq,
  output logic            o_lt,
  output logic            o_ltu
);

  // S1 issue register
  logic            v1_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [2:0]      opsel_reg;
  logic            sub_reg;
  logic            uns_reg;
  logic [4:0]      rd1_reg;

  // S2 output register
  logic            v2_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd2_reg;
  logic            eq_reg;
  logic            lt_reg;
  logic            ltu_reg;

  logic            adv1;
  logic            adv2;
  logic            accept;

  logic [XLEN-1:0] alu_result;
  logic            alu_eq;
  logic            alu_lt;
  logic            alu_ltu;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign adv2    = !v2_reg || i_ready;
  assign adv1    = !v1_reg || adv2;
  assign o_ready = adv1 && !i_rst;
  assign accept  = i_valid && o_ready && !i_flush;

  // Valid bits: reset and flush clear both; otherwise they follow the stall chain.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (adv1) v1_reg <= i_valid;
      if (adv2) v2_reg <= v1_reg;
    end
  end

  // S1 payload loads only on an accepted operation.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_reg     <= i_op_a;
      b_reg     <= i_op_b;
      opsel_reg <= i_opsel;
      sub_reg   <= i_sub;
      uns_reg   <= i_unsigned;
      rd1_reg   <= i_rd;
    end
  end

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .op_a         (a_reg),
    .op_b         (b_reg),
    .opsel        (opsel_reg),
    .sub          (sub_reg),
    .unsigned_cmp (uns_reg),
    .result       (alu_result),
    .eq           (alu_eq),
    .lt           (alu_lt),
    .ltu          (alu_ltu)
  );

  // S2 payload: cleared by reset, otherwise loaded whenever S2 advances.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_reg <= '0;
      rd2_reg    <= '0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
      ltu_reg    <= 1'b0;
    end else if (adv2) begin
      result_reg <= alu_result;
      rd2_reg    <= rd1_reg;
      eq_reg     <= alu_eq;
      lt_reg     <= alu_lt;
      ltu_reg    <= alu_ltu;
    end
  end

  assign o_valid  = v2_reg;
  assign o_result = result_reg;
  assign o_rd     = rd2_reg;
  assign o_eq     = eq_reg;
  assign o_lt     = lt_reg;
  assign o_ltu    = ltu_reg;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: directed cases plus a randomized run
// scored against an in-order queue of results from a behavioural ALU model.
module tb_alu_exec_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [2:0]  i_opsel;
  logic        i_sub;
  logic        i_unsigned;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_eq;
  logic        o_lt;
  logic        o_ltu;

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;

  // Expected items in acceptance order: {result, rd, eq, lt, ltu}
  logic [39:0] sb[$];

  alu_exec_pipe #(.XLEN(32)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .i_opsel    (i_opsel),
    .i_sub      (i_sub),
    .i_unsigned (i_unsigned),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_rd       (o_rd),
    .o_eq       (o_eq),
    .o_lt       (o_lt),
    .o_ltu      (o_ltu)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one operation straight from the ALU rules.
  function automatic logic [39:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic sub,
                                        input logic uns, input logic [4:0] rd);
    logic [31:0] r;
    logic        s_lt, u_lt;
    int          sh;
    sh   = int'(b % 32);
    s_lt = ($signed(a) < $signed(b));
    u_lt = (a < b);
    case (op)
      3'd0: r = sub ? (a - b) : (a + b);
      3'd1: r = a << sh;
      3'd2, 3'd3: r = {31'd0, uns ? u_lt : s_lt};
      3'd4: r = a ^ b;
      3'd5: begin
        if (sub) r = $signed(a) >>> sh;
        else     r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {r, rd, (a == b), s_lt, u_lt};
  endfunction

  function automatic logic [39:0] outs();
    return {o_result, o_rd, o_eq, o_lt, o_ltu};
  endfunction

  // One clock cycle: drive, check handshake and any consumed result, advance.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic sub, input logic uns,
                      input logic [4:0] rd, input logic rdy, input logic fl,
                      output logic acc);
    int cnt;
    i_valid = v; i_op_a = a; i_op_b = b; i_opsel = op; i_sub = sub;
    i_unsigned = uns; i_rd = rd; i_ready = rdy; i_flush = fl;
    #1;
    cnt = sb.size();
    check("o_ready", {63'd0, o_ready}, {63'd0, (cnt < 2) || rdy});
    if (cnt == 0) check("o_valid_empty", {63'd0, o_valid}, 64'd0);
    if (cnt >= 2) check("o_valid_full", {63'd0, o_valid}, 64'd1);
    acc = v && o_ready && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (o_valid && rdy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check("result_item", {24'd0, outs()}, {24'd0, sb.pop_front()});
          n_popped++;
        end
      end
      if (acc) sb.push_back(model(a, b, op, sub, uns, rd));
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, rdy, 1'b0, acc);
  endtask

  // Issue one op into an empty pipe, check latency and the test-plan constant.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic sub, input logic uns,
                          input logic [31:0] exp_res);
    logic acc;
    step(1'b1, a, b, op, sub, uns, 5'd7, 1'b0, 1'b0, acc);
    check({tag, "_accept"}, {63'd0, acc}, 64'd1);
    check({tag, "_lat_n"}, {63'd0, o_valid}, 64'd0);
    idle(1'b0);
    check({tag, "_lat_n1"}, {63'd0, o_valid}, 64'd1);
    check(tag, {32'd0, o_result}, {32'd0, exp_res});
    idle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] ra, rb, hold_res;
    logic [4:0]  hold_rd;
    logic        stalled;
    int          k;

    i_rst = 1'b1; i_valid = 1'b0; i_op_a = '0; i_op_b = '0; i_opsel = '0;
    i_sub = 1'b0; i_unsigned = 1'b0; i_rd = '0; i_flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_outs", {24'd0, outs()}, 64'd0);
    check("rst_o_ready", {63'd0, o_ready}, 64'd0);
    i_rst = 1'b0; #1;
    check("post_rst_o_ready", {63'd0, o_ready}, 64'd1);

    // Directed arithmetic / shift / compare cases
    directed("add_wrap", 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 32'h8000_0000);
    step(1'b1, 32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, acc);
    idle(1'b0);
    check("sub_flags", {24'd0, outs()}, {24'd0, 32'hFFFF_FFFE, 5'd3, 1'b0, 1'b1, 1'b1});
    idle(1'b1);
    directed("sra", 32'h8000_0000, 32'h24, 3'd5, 1'b1, 1'b0, 32'hF800_0000);
    directed("srl", 32'h8000_0000, 32'h24, 3'd5, 1'b0, 1'b0, 32'h0800_0000);
    directed("sll", 32'd1, 32'd31, 3'd1, 1'b0, 1'b0, 32'h8000_0000);
    directed("sltu", 32'd1, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 32'd1);
    step(1'b1, 32'd1, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, acc);
    idle(1'b0);
    check("slt_flags", {24'd0, outs()}, {24'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1});
    idle(1'b1);

    // Backpressure: 4 back-to-back adds, i_ready low for cycles 2..5
    k = 0;
    n_popped = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      hold_res = o_result; hold_rd = o_rd;
      stalled = o_valid && (cyc >= 2 && cyc <= 5);
      step(k < 4, 32'd100 * k, 32'd1, 3'd0, 1'b0, 1'b0, 5'(10 + k),
           !(cyc >= 2 && cyc <= 5), 1'b0, acc);
      if (acc) k++;
      if (stalled) check("bp_hold", {27'd0, hold_rd, hold_res}, {27'd0, o_rd, o_result});
    end
    check("bp_count", 64'(n_popped), 64'd4);
    check("bp_empty", 64'(sb.size()), 64'd0);

    // Flush with both stages full and an op offered in the same cycle
    step(1'b1, 32'd1, 32'd2, 3'd0, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, acc);
    step(1'b1, 32'd3, 32'd4, 3'd0, 1'b0, 1'b0, 5'd21, 1'b0, 1'b0, acc);
    step(1'b1, 32'd5, 32'd6, 3'd0, 1'b0, 1'b0, 5'd22, 1'b1, 1'b1, acc);
    check("flush_o_valid", {63'd0, o_valid}, 64'd0);
    step(1'b1, 32'd9, 32'd9, 3'd4, 1'b0, 1'b0, 5'd23, 1'b0, 1'b0, acc);
    idle(1'b0);
    check("post_flush_item", {24'd0, outs()}, {24'd0, 32'd0, 5'd23, 1'b1, 1'b0, 1'b0});
    idle(1'b1);
    check("post_flush_empty", 64'(sb.size()), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb % 64;
      step($urandom_range(0, 9) < 7, ra, rb, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, acc);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1'b1);
    check("drain_empty", 64'(sb.size()), 64'd0);

    // Reset mid-stall with both stages full
    step(1'b1, 32'hAAAA_5555, 32'h1234, 3'd6, 1'b0, 1'b0, 5'd30, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1, 32'h1, 3'd0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, acc);
    check("pre_rst_full", {63'd0, o_valid}, 64'd1);
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0; #1;
    check("rst_stall_o_ready", {63'd0, o_ready}, 64'd0);
    @(posedge i_clk); @(negedge i_clk); #1;
    check("rst_stall_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_stall_outs", {24'd0, outs()}, 64'd0);
    check("rst_stall_o_ready2", {63'd0, o_ready}, 64'd0);
    sb.delete();
    i_rst = 1'b0; i_valid = 1'b0; #1;
    check("rst_release_o_ready", {63'd0, o_ready}, 64'd1);
    directed("after_rst", 32'd40, 32'd2, 3'd0, 1'b0, 1'b0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
